data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 tb/tb_data_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the memory stage (master) and data_mem_responder (slave).
interface data_mem_responder_if;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_we;
   logic        req_re;
   logic [15:0] rdata;
   logic        stall;
   logic [2:0]  buf_count;
   logic        buf_empty;

   // A request is taken in the cycle it is presented unless stall=1, in which case
   // the master holds it unchanged; rdata is valid combinationally in that same cycle.
   modport master (
      output req_addr, req_wdata, req_we, req_re,
      input  rdata, stall, buf_count, buf_empty
   );

   modport slave (
      input  req_addr, req_wdata, req_we, req_re,
      output rdata, stall, buf_count, buf_empty
   );
endinterface

// File: rtl/data_mem_responder.sv
// 256x16 data memory with a posted write buffer drained in FIFO order on idle array cycles.
// Define DMEM_BYPASS_EN to forward buffered store data to loads instead of stalling them.
module data_mem_responder #(
   parameter int DEPTH = 4
) (
   input logic                  clk,
   input logic                  rst,
   data_mem_responder_if.slave  bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    ent_addr_q [DEPTH];
   logic [7:0]    ent_addr_d [DEPTH];
   logic [15:0]   ent_data_q [DEPTH];
   logic [15:0]   ent_data_d [DEPTH];
   logic [15:0]   mem [256];

   logic        full;
   logic        stall;
   logic        st_acc;
   logic        ld_acc;
   logic        drain;
   logic [15:0] rdata;
   logic        unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr[15:8];
   assign full = (cnt_q == CW'(DEPTH));

   // A store only looks at buffer space; a load that also has req_we set is not a load.
   always_comb begin
      stall = 1'b0;
      if (!rst) begin
         if (bus.req_we) begin
            stall = full;
         end else if (bus.req_re) begin
`ifdef DMEM_BYPASS_EN
            stall = 1'b0;
`else
            stall = (cnt_q != '0);
`endif
         end
      end
   end

   assign st_acc = !rst && bus.req_we && !stall;
   assign ld_acc = !rst && bus.req_re && !bus.req_we && !stall;
   assign drain  = !rst && (cnt_q != '0) && !ld_acc;

`ifdef DMEM_BYPASS_EN
   logic        hit;
   logic [15:0] hit_data;

   // Walk oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < cnt_q) &&
             (ent_addr_q[head_q + PW'(i)] == bus.req_addr[7:0])) begin
            hit      = 1'b1;
            hit_data = ent_data_q[head_q + PW'(i)];
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (ld_acc) rdata = hit ? hit_data : mem[bus.req_addr[7:0]];
   end
`else
   always_comb begin
      rdata = '0;
      if (ld_acc) rdata = mem[bus.req_addr[7:0]];
   end
`endif

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      cnt_d      = cnt_q;
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;
      if (drain) head_d = head_q + PW'(1);
      if (st_acc) begin
         ent_addr_d[tail_q] = bus.req_addr[7:0];
         ent_data_d[tail_q] = bus.req_wdata;
         tail_d             = tail_q + PW'(1);
      end
      case ({st_acc, drain})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
   end

   // Single array write port, owned by the drain; contents survive reset.
   always_ff @(posedge clk) begin
      if (drain) mem[ent_addr_q[head_q]] <= ent_data_q[head_q];
   end

   assign bus.stall     = stall;
   assign bus.rdata     = rdata;
   assign bus.buf_count = 3'(cnt_q);
   assign bus.buf_empty = rst || (cnt_q == '0);

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a queue + array reference model.
// Builds with or without DMEM_BYPASS_EN; the model follows the same define.
module tb_data_mem_responder;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_mem_responder_if bus ();
   data_mem_responder #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   // reference model: pending stores in arrival order, plus the array image
   logic [23:0] buf_q[$];
   logic [15:0] mdl_mem [256];
   logic [15:0] exp_q[$];

   int          errors = 0;
   int          checks = 0;
   logic        exp_stall, exp_load, exp_empty;
   logic [2:0]  exp_count;
   logic [15:0] exp_rd;
   logic [20:0] got, want;
   logic        cur_r, cur_we;
   logic [15:0] cur_addr, cur_wdata;

   function automatic logic [15:0] lookup(input logic [7:0] a);
      logic [15:0] v;
      v = mdl_mem[a];
`ifdef DMEM_BYPASS_EN
      foreach (buf_q[i]) if (buf_q[i][23:16] == a) v = buf_q[i][15:0];
`endif
      return v;
   endfunction

   // Apply one cycle's request and derive what the outputs must be this cycle.
   task automatic drive(input logic r, input logic we, input logic re,
                        input logic [15:0] addr, input logic [15:0] wdata);
      rst = r; bus.req_we = we; bus.req_re = re;
      bus.req_addr = addr; bus.req_wdata = wdata;
      cur_r = r; cur_we = we; cur_addr = addr; cur_wdata = wdata;
      exp_stall = 1'b0;
      if (!r) begin
         if (we) exp_stall = (buf_q.size() == DEPTH);
`ifdef DMEM_BYPASS_EN
         else if (re) exp_stall = 1'b0;
`else
         else if (re) exp_stall = (buf_q.size() > 0);
`endif
      end
      exp_load  = !r && re && !we && !exp_stall;
      exp_q.push_back(exp_load ? lookup(addr[7:0]) : 16'h0);
      exp_count = 3'(buf_q.size());
      exp_empty = r || (buf_q.size() == 0);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      if (cur_r) buf_q.delete();
      else begin
         if (buf_q.size() > 0 && !exp_load) begin
            mdl_mem[buf_q[0][23:16]] = buf_q[0][15:0];
            void'(buf_q.pop_front());
         end
         if (cur_we && !exp_stall) buf_q.push_back({cur_addr[7:0], cur_wdata});
      end
      #1;
   endtask

   task automatic settle();
      for (int n = 0; n < 4 * DEPTH && buf_q.size() > 0; n++) begin
         drive(0, 0, 0, 16'h0, 16'h0);
         void'(exp_q.pop_front());
         tick();
      end
   endtask

   task automatic test_reset();
      drive(1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      exp_rd = exp_q.pop_front();
      checks++;
      if ({bus.stall, bus.rdata, bus.buf_empty} !== {exp_stall, exp_rd, exp_empty}) begin
         errors++;
         $display("FAIL reset_first got=%h want=%h", {bus.stall, bus.rdata, bus.buf_empty},
                  {exp_stall, exp_rd, exp_empty});
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
         got = {bus.stall, bus.rdata, bus.buf_count, bus.buf_empty};
         exp_rd = exp_q.pop_front();
         want = {exp_stall, exp_rd, exp_count, exp_empty};
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL reset_hold stall/rdata/cnt/empty got=%h want=%h", got, want);
         end
         tick();
      end
   endtask

   task automatic test_init();
      for (int a = 0; a < 256; a++) begin
         drive(0, 1, 0, {8'($urandom), 8'(a)}, 16'($urandom));
         got = {bus.stall, bus.rdata, bus.buf_count, bus.buf_empty};
         exp_rd = exp_q.pop_front();
         want = {exp_stall, exp_rd, exp_count, exp_empty};
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL init a=%0d got=%h want=%h", a, got, want);
         end
         tick();
      end
      settle();
   endtask

   task automatic test_write_read();
      logic acc;
      int   n;
      drive(0, 1, 0, 16'h00A5, 16'h1234);
      exp_rd = exp_q.pop_front();
      checks++;
      if (bus.stall !== 1'b0 || bus.rdata !== exp_rd) begin
         errors++; $display("FAIL wr_store stall=%b rdata=%h want 0/%h", bus.stall, bus.rdata, exp_rd);
      end
      tick();
      n = 0;
      do begin
         drive(0, 0, 1, 16'h00A5, 16'h0);
         got = {bus.stall, bus.rdata, bus.buf_count, bus.buf_empty};
         exp_rd = exp_q.pop_front();
         want = {exp_stall, exp_rd, exp_count, exp_empty};
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL wr_load got=%h want=%h", got, want);
         end
         acc = !exp_stall;
         if (acc) begin
            checks++;
            if (bus.rdata !== 16'h1234) begin
               errors++; $display("FAIL wr_data got=%h want=1234", bus.rdata);
            end
         end
         tick();
         n++;
      end while (!acc && n < 4 * DEPTH);
      checks++;
      if (!acc) begin errors++; $display("FAIL wr_timeout load never accepted"); end
      drive(0, 0, 0, 16'h0, 16'h0);
      void'(exp_q.pop_front());
      tick();
      drive(0, 0, 1, 16'h00A5, 16'h0);
      void'(exp_q.pop_front());
      checks++;
      if ({bus.buf_empty, bus.stall, bus.rdata} !== {1'b1, 1'b0, 16'h1234}) begin
         errors++; $display("FAIL wr_array empty/stall/rdata got=%h want=11234",
                            {bus.buf_empty, bus.stall, bus.rdata});
      end
      tick();
   endtask

   task automatic test_fill_stall();
      for (int i = 0; i < 8; i++) begin
         if (i < 6) drive(0, 1, 1, 16'h0020 + 16'(i), 16'($urandom));
         else       drive(0, 1, 0, 16'h0020 + 16'(i), 16'($urandom));
         got = {bus.stall, bus.rdata, bus.buf_count, bus.buf_empty};
         exp_rd = exp_q.pop_front();
         want = {exp_stall, exp_rd, exp_count, exp_empty};
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL fill i=%0d got=%h want=%h", i, got, want);
         end
         tick();
      end
      settle();
   endtask

   task automatic test_order();
      logic acc;
      int   n;
      drive(0, 1, 0, 16'h0010, 16'h1111); void'(exp_q.pop_front()); tick();
      drive(0, 1, 0, 16'h0010, 16'h2222); void'(exp_q.pop_front()); tick();
      for (int pass = 0; pass < 2; pass++) begin
         n = 0;
         do begin
            drive(0, 0, 1, 16'h0010, 16'h0);
            exp_rd = exp_q.pop_front();
            acc = !exp_stall;
            checks++;
            if ({bus.stall, bus.rdata} !== {exp_stall, exp_rd}) begin
               errors++; $display("FAIL order_model pass=%0d got=%h want=%h", pass,
                                  {bus.stall, bus.rdata}, {exp_stall, exp_rd});
            end
            if (acc) begin
               checks++;
               if (bus.rdata !== 16'h2222) begin
                  errors++; $display("FAIL order_data pass=%0d got=%h want=2222", pass, bus.rdata);
               end
            end
            tick();
            n++;
         end while (!acc && n < 4 * DEPTH);
         checks++;
         if (!acc) begin errors++; $display("FAIL order_timeout pass=%0d", pass); end
         settle();
      end
   endtask

   task automatic test_reset_pending();
      logic [15:0] pre32, d;
      pre32 = mdl_mem[8'h32];
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 16'h0030 + 16'(i), 16'($urandom) | 16'h8000);
         void'(exp_q.pop_front());
         tick();
      end
      drive(1, 0, 0, 16'h0, 16'h0); void'(exp_q.pop_front()); tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 16'h0030 + 16'(i), 16'h0);
         exp_rd = exp_q.pop_front();
         got = {bus.stall, bus.rdata, bus.buf_count, bus.buf_empty};
         want = {exp_stall, exp_rd, exp_count, exp_empty};
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL rstpend i=%0d got=%h want=%h", i, got, want);
         end
         if (i == 2) begin
            checks++;
            if ({bus.buf_count, bus.rdata} !== {3'd0, pre32}) begin
               errors++; $display("FAIL rstpend_discard got=%h want=%h", {bus.buf_count, bus.rdata},
                                  {3'd0, pre32});
            end
         end
         tick();
      end
      d = 16'($urandom);
      drive(0, 1, 0, 16'h01FF, d); void'(exp_q.pop_front()); tick();
      settle();
      drive(0, 0, 1, 16'h00FF, 16'h0);
      void'(exp_q.pop_front());
      checks++;
      if (bus.rdata !== d) begin
         errors++; $display("FAIL alias got=%h want=%h", bus.rdata, d);
      end
      tick();
   endtask

   task automatic test_simul();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 16'h0050 + 16'(i), 16'($urandom));
         got = {bus.stall, bus.rdata, bus.buf_count, bus.buf_empty};
         exp_rd = exp_q.pop_front();
         want = {exp_stall, exp_rd, exp_count, exp_empty};
         checks++;
         if (got !== want || bus.rdata !== 16'h0) begin
            errors++; $display("FAIL simul i=%0d got=%h want=%h", i, got, want);
         end
         tick();
      end
      drive(0, 0, 0, 16'h0, 16'h0);
      void'(exp_q.pop_front());
      checks++;
      if (bus.buf_count !== 3'd1) begin
         errors++; $display("FAIL simul_count got=%0d want=1", bus.buf_count);
      end
      tick();
      settle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom),
               {8'($urandom), 8'h40 + 8'($urandom_range(0, 5))}, 16'($urandom));
         got = {bus.stall, bus.rdata, bus.buf_count, bus.buf_empty};
         exp_rd = exp_q.pop_front();
         want = {exp_stall, exp_rd, exp_count, exp_empty};
         checks++;
         if (got !== want) begin
            errors++; $display("FAIL random i=%0d got=%h want=%h", i, got, want);
         end
         tick();
      end
      settle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_we = 1'b0; bus.req_re = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      test_reset();
      test_init();
      test_write_read();
      test_fill_stall();
      test_order();
      test_reset_pending();
      test_simul();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
